// File: rtl/riscv_pkg.sv
// Shared pipeline constants: functional-unit latencies and scoreboard field widths.
package riscv_pkg;

    localparam int unsigned LAT_ALU  = 1;
    localparam int unsigned LAT_LOAD = 2;
    localparam int unsigned LAT_MUL  = 3;
    localparam int unsigned LAT_DIV  = 8;

    localparam int unsigned RA_W  = 5;
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/hazard_sb_cnt.sv
// One scoreboard entry: saturating down-counter with parallel load.
module hazard_sb_cnt
    import riscv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt > CNT_W'(1));

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage latency scoreboard: stalls on RAW/WAW hazards, squashes on branch flush.
// Build option FWD_EN: bypass network present, so results count as available at forward point.
module hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned MAX_LAT  = LAT_DIV,
    parameter int unsigned WB_EXTRA = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [RA_W-1:0]     id_rs1,
    input  logic [RA_W-1:0]     id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [RA_W-1:0]     id_rd,
    input  logic                id_we,
    input  logic [CNT_W-1:0]    id_lat,
    input  logic                branch_flush,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                id_ex_bubble,
    output logic                if_id_flush,
    output logic [NUM_REGS-1:0] sb_busy
);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    lat_eff;
    logic [CNT_W-1:0]    load_val;
    logic                raw1, raw2, waw, stall, issue, wr_en;

    assign lat_eff = (id_lat == '0)              ? CNT_W'(1) :
                     (id_lat > CNT_W'(MAX_LAT))  ? CNT_W'(MAX_LAT) : id_lat;

`ifdef FWD_EN
    assign load_val = lat_eff;
`else
    assign load_val = lat_eff + CNT_W'(WB_EXTRA);
`endif

    // RAW reads pre-issue state, so an instruction never hazards on its own rd
    assign raw1  = id_use_rs1 && (id_rs1 != '0) && busy[id_rs1];
    assign raw2  = id_use_rs2 && (id_rs2 != '0) && busy[id_rs2];
    assign waw   = id_we && (id_rd != '0) && (cnt[id_rd] > load_val);
    assign stall = id_valid && !branch_flush && (raw1 || raw2 || waw);
    assign issue = id_valid && !branch_flush && !stall;
    assign wr_en = issue && id_we && (id_rd != '0);

    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        hazard_sb_cnt u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (wr_en && (id_rd == RA_W'(r))),
            .load_val (load_val),
            .cnt      (cnt[r]),
            .busy     (busy[r])
        );
    end

    assign sb_busy = busy;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (branch_flush) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard; expectations follow the FWD_EN build option.
module tb_hazard_scoreboard;
    import riscv_pkg::*;

`ifdef FWD_EN
    localparam int WB = 0;
`else
    localparam int WB = 2;
`endif

    typedef enum logic [1:0] {K_RUN, K_STALL, K_FLUSH} kind_e;

    typedef struct {
        logic        valid;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic [3:0]  lat;
        logic        fl;
        kind_e       kind;
        logic        chk_busy;
        logic [31:0] busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs1, id_use_rs2, id_we, branch_flush;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_lat;
    logic        pc_write, if_id_write, id_ex_bubble, if_id_flush;
    logic [31:0] sb_busy;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    hazard_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_we        (id_we),
        .id_lat       (id_lat),
        .branch_flush (branch_flush),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_bubble (id_ex_bubble),
        .if_id_flush  (if_id_flush),
        .sb_busy      (sb_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic push(input int v, input int rs1, input int u1, input int rs2, input int u2,
                        input int rd, input int we, input int lat, input int fl,
                        input kind_e k, input int cb, input logic [31:0] bm);
        vec_t e;
        e.valid = 1'(v);  e.rs1 = 5'(rs1); e.u1 = 1'(u1); e.rs2 = 5'(rs2); e.u2 = 1'(u2);
        e.rd = 5'(rd);    e.we = 1'(we);   e.lat = 4'(lat); e.fl = 1'(fl);
        e.kind = k;       e.chk_busy = 1'(cb); e.busy = bm;
        vecs.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) push(0, 0, 0, 0, 0, 0, 0, 0, 0, K_RUN, (k == n - 1) ? 1 : 0, '0);
    endtask

    task automatic drive(input vec_t e);
        id_valid = e.valid; id_rs1 = e.rs1; id_use_rs1 = e.u1; id_rs2 = e.rs2; id_use_rs2 = e.u2;
        id_rd = e.rd; id_we = e.we; id_lat = e.lat; branch_flush = e.fl;
    endtask

    task automatic check_ctl(input int idx, input kind_e k);
        logic ep, eb, ef;
        ep = (k != K_STALL);
        eb = (k != K_RUN);
        ef = (k == K_FLUSH);
        check("pc_write", idx, 32'(pc_write), 32'(ep));
        check("if_id_write", idx, 32'(if_id_write), 32'(ep));
        check("id_ex_bubble", idx, 32'(id_ex_bubble), 32'(eb));
        check("if_id_flush", idx, 32'(if_id_flush), 32'(ef));
    endtask

    logic [31:0] bit_of [32];
    vec_t cur;
    int L, M;

    initial begin
        for (int i = 0; i < 32; i++) bit_of[i] = 32'd1 << i;

        // lw x5 then add x6,x5,x1
        L = LAT_LOAD + WB;
        push(1, 1, 1, 0, 0, 5, 1, LAT_LOAD, 0, K_RUN, 1, '0);
        for (int k = 0; k < L - 1; k++) push(1, 5, 1, 1, 1, 6, 1, LAT_ALU, 0, K_STALL, 1, bit_of[5]);
        push(1, 5, 1, 1, 1, 6, 1, LAT_ALU, 0, K_RUN, 1, '0);
        idle(12);
        // div x7 then add x8,x7,x0
        L = LAT_DIV + WB;
        push(1, 2, 1, 0, 0, 7, 1, LAT_DIV, 0, K_RUN, 1, '0);
        for (int k = 0; k < L - 1; k++) push(1, 7, 1, 0, 1, 8, 1, LAT_ALU, 0, K_STALL, 1, bit_of[7]);
        push(1, 7, 1, 0, 1, 8, 1, LAT_ALU, 0, K_RUN, 1, '0);
        idle(12);
        // addi x3 then consumer of x3
        L = LAT_ALU + WB;
        push(1, 0, 0, 0, 0, 3, 1, LAT_ALU, 0, K_RUN, 1, '0);
        for (int k = 0; k < L - 1; k++) push(1, 4, 1, 3, 1, 0, 0, LAT_ALU, 0, K_STALL, 1, bit_of[3]);
        push(1, 4, 1, 3, 1, 0, 0, LAT_ALU, 0, K_RUN, 1, '0);
        idle(12);
        // lw x0 then use x0
        push(1, 1, 1, 0, 0, 0, 1, LAT_LOAD, 0, K_RUN, 1, '0);
        push(1, 0, 1, 0, 1, 0, 0, LAT_ALU, 0, K_RUN, 1, '0);
        // WAW: div x9 then addi x9
        L = LAT_DIV + WB;
        M = LAT_ALU + WB;
        push(1, 0, 0, 0, 0, 9, 1, LAT_DIV, 0, K_RUN, 1, '0);
        for (int k = 0; k < L - M; k++) push(1, 0, 0, 0, 0, 9, 1, LAT_ALU, 0, K_STALL, 1, bit_of[9]);
        push(1, 0, 0, 0, 0, 9, 1, LAT_ALU, 0, K_RUN, 1, (M > 1) ? bit_of[9] : '0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, K_RUN, 1, (M > 1) ? bit_of[9] : '0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, K_RUN, 1, (M - 1 > 1) ? bit_of[9] : '0);
        idle(12);
        // branch flush while dependent of lw x12 is stalled; its rd x13 must not be recorded
        L = LAT_LOAD + WB;
        push(1, 1, 1, 0, 0, 12, 1, LAT_LOAD, 0, K_RUN, 1, '0);
        push(1, 12, 1, 0, 0, 13, 1, LAT_LOAD, 0, K_STALL, 1, bit_of[12]);
        push(1, 12, 1, 0, 0, 13, 1, LAT_LOAD, 1, K_FLUSH, 1, (L - 1 > 1) ? bit_of[12] : '0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, K_RUN, 1, (L - 2 > 1) ? bit_of[12] : '0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, K_RUN, 1, '0);
        idle(12);
        // id_lat above MAX_LAT saturates
        L = LAT_DIV + WB;
        push(1, 0, 0, 0, 0, 10, 1, 15, 0, K_RUN, 1, '0);
        for (int k = 0; k < L - 1; k++) push(1, 0, 0, 10, 1, 0, 0, LAT_ALU, 0, K_STALL, 1, bit_of[10]);
        push(1, 0, 0, 10, 1, 0, 0, LAT_ALU, 0, K_RUN, 1, '0);
        idle(12);
        // id_lat = 0 behaves as 1
        L = LAT_ALU + WB;
        push(1, 0, 0, 0, 0, 11, 1, 0, 0, K_RUN, 1, '0);
        for (int k = 0; k < L - 1; k++) push(1, 11, 1, 0, 0, 0, 0, LAT_ALU, 0, K_STALL, 1, bit_of[11]);
        push(1, 11, 1, 0, 0, 0, 0, LAT_ALU, 0, K_RUN, 1, '0);
        idle(12);

        // Reset state
        rst_n = 1'b0;
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, K_RUN, 0, '0);
        drive(vecs[$]);
        void'(vecs.pop_back());
        #3;
        check_ctl(-1, K_RUN);
        check("sb_busy_reset", -1, sb_busy, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check_ctl(i, vecs[i].kind);
            if (vecs[i].chk_busy) check("sb_busy", i, sb_busy, vecs[i].busy);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while div x20 has cnt=5 and a dependent waits in ID
        L = LAT_DIV + WB;
        push(1, 0, 0, 0, 0, 20, 1, LAT_DIV, 0, K_RUN, 0, '0);
        cur = vecs[$];
        drive(cur);
        @(negedge clk);
        check_ctl(1000, K_RUN);
        @(posedge clk);
        #1;
        push(1, 20, 1, 0, 0, 21, 1, LAT_DIV, 0, K_STALL, 0, '0);
        cur = vecs[$];
        drive(cur);
        for (int k = 0; k < L - 5; k++) begin
            @(negedge clk);
            check_ctl(1001 + k, K_STALL);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_ctl(1100, K_STALL);
        check("sb_busy_pre_reset", 1100, sb_busy, bit_of[20]);
        #1 rst_n = 1'b0;
        #1;
        check_ctl(1101, K_RUN);
        check("sb_busy_async_clear", 1101, sb_busy, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_ctl(1102, K_RUN);
        check("sb_busy_after_release", 1102, sb_busy, '0);
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        @(negedge clk);
        check("sb_busy_dep_issued", 1103, sb_busy, bit_of[21]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
